// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller for the RV32I pipeline.
// Owns mstatus/mie/mip/mtvec/mepc/mcause/counters and issues a registered one-cycle redirect on traps and mret.
module csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_1000,
    parameter logic [31:0] HARTID      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] csr_raddr,
    output logic [31:0] csr_rdata,
    input  logic        csr_wvalid,
    input  logic        csr_we,
    input  logic [11:0] csr_waddr,
    input  logic [31:0] csr_wdata,
    input  logic        exc_req,
    input  logic [3:0]  exc_cause,
    input  logic [31:0] exc_pc,
    input  logic        mret_req,
    input  logic        irq_ext,
    input  logic        irq_sw,
    input  logic        irq_timer,
    input  logic [31:0] irq_pc,
    input  logic        irq_ok,
    input  logic        retire,
    output logic        trap_redirect,
    output logic [31:0] trap_target
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MISA     = 12'h301;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTRH  = 12'hB82;
    localparam logic [11:0] A_MHARTID  = 12'hF14;

    localparam logic [31:0] MISA_VAL = 32'h4000_0100;
    localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

    localparam logic RUN   = 1'b0;
    localparam logic REDIR = 1'b1;

    logic        state;
    logic        st_mie, st_mpie;
    logic [31:0] mie_r, mip_r, mtvec_r, mscratch_r, mepc_r, mcause_r;
    logic [63:0] mcycle_r, minstret_r;

    // MODE values 2 and 3 are reserved and collapse to direct mode.
    function automatic logic [31:0] legal_mtvec(input logic [31:0] v);
        return {v[31:2], (v[1] ? 2'b00 : v[1:0])};
    endfunction

    // External beats software beats timer.
    function automatic logic [3:0] irq_code(input logic [31:0] pend);
        if (pend[11])     return 4'd11;
        else if (pend[3]) return 4'd3;
        else              return 4'd7;
    endfunction

    logic        wr;
    logic [31:0] mstatus_val, pending, vec_base, target;
    logic [3:0]  code;
    logic        take_exc, take_mret, take_irq, take_any;

    assign wr          = csr_wvalid && csr_we;
    assign mstatus_val = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
    assign pending     = mie_r & mip_r;
    assign code        = irq_code(pending);
    assign vec_base    = {mtvec_r[31:2], 2'b00};

    assign take_exc  = (state == RUN) && exc_req;
    assign take_mret = (state == RUN) && !exc_req && mret_req;
    assign take_irq  = (state == RUN) && st_mie && (|pending) && irq_ok && !exc_req && !mret_req;
    assign take_any  = take_exc || take_mret || take_irq;

    always_comb begin
        target = vec_base;
        if (take_mret)
            target = mepc_r;
        else if (take_irq && mtvec_r[1:0] == 2'b01)
            target = vec_base + {26'b0, code, 2'b00};
    end

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_raddr)
            A_MSTATUS:  csr_rdata = mstatus_val;
            A_MISA:     csr_rdata = MISA_VAL;
            A_MIE:      csr_rdata = mie_r;
            A_MTVEC:    csr_rdata = mtvec_r;
            A_MSCRATCH: csr_rdata = mscratch_r;
            A_MEPC:     csr_rdata = mepc_r;
            A_MCAUSE:   csr_rdata = mcause_r;
            A_MIP:      csr_rdata = mip_r;
            A_MCYCLE:   csr_rdata = mcycle_r[31:0];
            A_MCYCLEH:  csr_rdata = mcycle_r[63:32];
            A_MINSTRET: csr_rdata = minstret_r[31:0];
            A_MINSTRH:  csr_rdata = minstret_r[63:32];
            A_MHARTID:  csr_rdata = HARTID;
            default:    csr_rdata = 32'h0;
        endcase
    end

    // CSR writes land first; trap/mret field updates below override them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RUN;
            st_mie        <= 1'b0;
            st_mpie       <= 1'b0;
            mie_r         <= 32'h0;
            mip_r         <= 32'h0;
            mtvec_r       <= MTVEC_RESET;
            mscratch_r    <= 32'h0;
            mepc_r        <= 32'h0;
            mcause_r      <= 32'h0;
            mcycle_r      <= 64'h0;
            minstret_r    <= 64'h0;
            trap_redirect <= 1'b0;
            trap_target   <= 32'h0;
        end else begin
            mip_r <= {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};

            if (wr) begin
                case (csr_waddr)
                    A_MSTATUS:  begin st_mie <= csr_wdata[3]; st_mpie <= csr_wdata[7]; end
                    A_MIE:      mie_r      <= csr_wdata & IRQ_MASK;
                    A_MTVEC:    mtvec_r    <= legal_mtvec(csr_wdata);
                    A_MSCRATCH: mscratch_r <= csr_wdata;
                    A_MEPC:     mepc_r     <= csr_wdata & ~32'h3;
                    A_MCAUSE:   mcause_r   <= csr_wdata;
                    default:    ;
                endcase
            end

            if (wr && csr_waddr == A_MCYCLE)       mcycle_r[31:0]  <= csr_wdata;
            else if (wr && csr_waddr == A_MCYCLEH) mcycle_r[63:32] <= csr_wdata;
            else                                   mcycle_r        <= mcycle_r + 64'd1;

            if (wr && csr_waddr == A_MINSTRET)     minstret_r[31:0]  <= csr_wdata;
            else if (wr && csr_waddr == A_MINSTRH) minstret_r[63:32] <= csr_wdata;
            else if (retire)                       minstret_r        <= minstret_r + 64'd1;

            if (take_exc || take_irq) begin
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
                mepc_r   <= (take_exc ? exc_pc : irq_pc) & ~32'h3;
                mcause_r <= take_exc ? {28'b0, exc_cause} : {1'b1, 27'b0, code};
            end else if (take_mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end

            trap_redirect <= take_any;
            if (take_any) trap_target <= target;

            case (state)
                RUN:     if (take_any) state <= REDIR;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit: CSR access, traps, mret, counters and reset.
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_wvalid, csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        exc_req;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc;
    logic        mret_req;
    logic        irq_ext, irq_sw, irq_timer;
    logic [31:0] irq_pc;
    logic        irq_ok, retire;
    logic        trap_redirect;
    logic [31:0] trap_target;

    int checks   = 0;
    int failures = 0;

    csr_unit #(.MTVEC_RESET(32'h0000_1000), .HARTID(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_wvalid(csr_wvalid), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc), .mret_req(mret_req),
        .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
        .irq_pc(irq_pc), .irq_ok(irq_ok), .retire(retire),
        .trap_redirect(trap_redirect), .trap_target(trap_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr, input string tag, input logic [31:0] exp);
        csr_raddr = addr;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data, input logic valid);
        csr_wvalid = valid;
        csr_we     = 1'b1;
        csr_waddr  = addr;
        csr_wdata  = data;
        tick();
        csr_wvalid = 1'b0;
        csr_we     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; csr_raddr = '0; csr_wvalid = 0; csr_we = 0; csr_waddr = '0; csr_wdata = '0;
        exc_req = 0; exc_cause = '0; exc_pc = '0; mret_req = 0;
        irq_ext = 0; irq_sw = 0; irq_timer = 0; irq_pc = '0; irq_ok = 0; retire = 0;
        tick(); tick();
        check("rst_redirect", {31'b0, trap_redirect}, 32'h0);
        check("rst_target", trap_target, 32'h0);
        rst_n = 1'b1;
        rd(12'h300, "rst_mstatus", 32'h0000_1800);
        rd(12'h305, "rst_mtvec", 32'h0000_1000);
        rd(12'h301, "misa", 32'h4000_0100);
        rd(12'hF14, "mhartid", 32'h0);
        rd(12'h341, "rst_mepc", 32'h0);
        rd(12'h7C0, "unmapped", 32'h0);

        wr(12'h301, 32'hFFFF_FFFF, 1'b1);
        rd(12'h301, "misa_ro", 32'h4000_0100);

        // Vectored interrupt on the timer line
        wr(12'h305, 32'h0000_2001, 1'b1);
        rd(12'h305, "mtvec_vec", 32'h0000_2001);
        wr(12'h304, 32'hFFFF_FFFF, 1'b1);
        rd(12'h304, "mie_mask", 32'h0000_0888);
        wr(12'h300, 32'h0000_0008, 1'b1);
        rd(12'h300, "mstatus_mie", 32'h0000_1808);
        irq_timer = 1; irq_pc = 32'h104; irq_ok = 1;
        tick();
        check("irq_lat_redirect", {31'b0, trap_redirect}, 32'h0);
        rd(12'h344, "mip_mtip", 32'h0000_0080);
        tick();
        irq_timer = 0;
        check("irq_redirect", {31'b0, trap_redirect}, 32'h1);
        check("irq_target", trap_target, 32'h0000_201C);
        rd(12'h341, "irq_mepc", 32'h0000_0104);
        rd(12'h342, "irq_mcause", 32'h8000_0007);
        rd(12'h300, "irq_mstatus", 32'h0000_1880);
        tick();
        check("irq_pulse_end", {31'b0, trap_redirect}, 32'h0);

        // Exception beats mret and interrupt; REDIR ignores the next events
        exc_req = 1; exc_cause = 4'd11; exc_pc = 32'h208; irq_ext = 1; mret_req = 1;
        tick();
        check("exc_redirect", {31'b0, trap_redirect}, 32'h1);
        check("exc_target", trap_target, 32'h0000_2000);
        rd(12'h342, "exc_mcause", 32'h0000_000B);
        rd(12'h341, "exc_mepc", 32'h0000_0208);
        exc_cause = 4'd2; exc_pc = 32'h300;
        tick();
        exc_req = 0; mret_req = 0; irq_ext = 0;
        check("redir_ignore", {31'b0, trap_redirect}, 32'h0);
        rd(12'h342, "redir_mcause", 32'h0000_000B);
        rd(12'h341, "redir_mepc", 32'h0000_0208);
        tick(); tick();

        // mret and WARL mtvec
        wr(12'h305, 32'h0000_3003, 1'b1);
        rd(12'h305, "mtvec_warl", 32'h0000_3000);
        wr(12'h300, 32'h0000_0080, 1'b1);
        mret_req = 1;
        tick();
        mret_req = 0;
        check("mret_redirect", {31'b0, trap_redirect}, 32'h1);
        check("mret_target", trap_target, 32'h0000_0208);
        rd(12'h300, "mret_mstatus", 32'h0000_1888);

        // Ext and timer together in direct mode: external wins
        irq_ext = 1; irq_timer = 1; irq_pc = 32'h10E;
        tick();
        check("prio_lat", {31'b0, trap_redirect}, 32'h0);
        tick();
        irq_ext = 0; irq_timer = 0;
        check("prio_redirect", {31'b0, trap_redirect}, 32'h1);
        check("prio_target", trap_target, 32'h0000_3000);
        rd(12'h342, "prio_mcause", 32'h8000_000B);
        rd(12'h341, "prio_mepc", 32'h0000_010C);
        tick(); tick();

        // mepc write gating and alignment
        wr(12'h341, 32'h0000_0123, 1'b0);
        rd(12'h341, "mepc_novalid", 32'h0000_010C);
        wr(12'h341, 32'h0000_0123, 1'b1);
        rd(12'h341, "mepc_align", 32'h0000_0120);

        // Counters
        wr(12'hB00, 32'hFFFF_FFFF, 1'b1);
        rd(12'hB00, "mcycle_load", 32'hFFFF_FFFF);
        tick();
        rd(12'hB00, "mcycle_wrap", 32'h0);
        rd(12'hB80, "mcycleh_carry", 32'h1);
        retire = 1;
        tick(); tick(); tick();
        retire = 0;
        tick();
        rd(12'hB02, "minstret", 32'h3);
        rd(12'hB82, "minstreth", 32'h0);

        // Reset during REDIR
        exc_req = 1; exc_cause = 4'd2; exc_pc = 32'h400;
        tick();
        exc_req = 0;
        check("pre_rst_redirect", {31'b0, trap_redirect}, 32'h1);
        rst_n = 0;
        tick();
        check("mid_rst_redirect", {31'b0, trap_redirect}, 32'h0);
        check("mid_rst_target", trap_target, 32'h0);
        rd(12'h300, "mid_rst_mstatus", 32'h0000_1800);
        rst_n = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
